// File: rtl/ovl_next_multi_checker.sv
// Multi-window "next" checker: every start_event is tracked in a NUM_CKS-deep
// shift register so overlapping windows are each checked on their own.
module ovl_next_multi_checker #(
  parameter int unsigned NUM_CKS             = 1,
  parameter bit          CHECK_OVERLAPPING   = 1'b1,
  parameter bit          CHECK_MISSING_START = 1'b1,
  parameter int unsigned CNT_W               = 16,
  localparam int unsigned PW                 = $clog2(NUM_CKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_event,
  input  logic             test_expr,
  output logic             fire_missing_test,
  output logic             fire_missing_start,
  output logic             fire_overlap,
  output logic [PW-1:0]    pending_count,
  output logic [CNT_W-1:0] cov_starts,
  output logic [CNT_W-1:0] cov_satisfied,
  output logic [CNT_W-1:0] cov_errors
);

  if (NUM_CKS < 1 || NUM_CKS > 256) begin : g_bad_num_cks
    $error("ovl_next_multi_checker: NUM_CKS must be in 1..256");
  end
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("ovl_next_multi_checker: CNT_W must be in 2..32");
  end

  logic [NUM_CKS-1:0] sr;
  logic [NUM_CKS-1:0] sr_next;
  logic [PW-1:0]      pop_next;
  logic               mature;
  logic               pend_other;
  logic               miss_test;
  logic               miss_start;
  logic               overlap;
  logic               satisfied;
  logic               any_viol;

  always_comb begin
    sr_next    = '0;
    sr_next[0] = start_event;
    for (int unsigned k = 1; k < NUM_CKS; k++) begin
      sr_next[k] = sr[k-1];
    end
  end

  // Pending for overlap excludes the top stage: a start maturing now is retiring.
  always_comb begin
    pend_other = 1'b0;
    for (int unsigned k = 0; k + 1 < NUM_CKS; k++) begin
      pend_other = pend_other | sr[k];
    end
  end

  always_comb begin
    pop_next = '0;
    for (int unsigned k = 0; k < NUM_CKS; k++) begin
      pop_next = pop_next + PW'(sr_next[k]);
    end
  end

  assign mature     = sr[NUM_CKS-1];
  assign miss_test  = mature & ~test_expr;
  assign miss_start = CHECK_MISSING_START & test_expr & ~mature;
  assign overlap    = CHECK_OVERLAPPING & start_event & pend_other;
  assign satisfied  = mature & test_expr;
  assign any_viol   = enable & (miss_test | miss_start | overlap);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr                 <= '0;
      fire_missing_test  <= 1'b0;
      fire_missing_start <= 1'b0;
      fire_overlap       <= 1'b0;
      pending_count      <= '0;
      cov_starts         <= '0;
      cov_satisfied      <= '0;
      cov_errors         <= '0;
    end else begin
      sr                 <= sr_next;
      fire_missing_test  <= enable & miss_test;
      fire_missing_start <= enable & miss_start;
      fire_overlap       <= enable & overlap;
      pending_count      <= pop_next;
      cov_starts         <= sat_inc(cov_starts, start_event);
      cov_satisfied      <= sat_inc(cov_satisfied, satisfied);
      cov_errors         <= sat_inc(cov_errors, any_viol);
    end
  end

endmodule
